// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : bin2bcd_seq
//  Description : Sequential 14-bit binary to 4-digit BCD converter. It uses
//                shift-and-add-3 (double-dabble), one input bit per clock,
//                and feeds the seven-segment scan stage. The digit outputs are
//                registered and change only when a conversion completes, so
//                the multiplexed display never shows a partial result.
//                Inputs above 9999 saturate to 9999 and raise ovf.
//                Optional leading-zero blanking replaces the leading zero
//                digits with BLANK_CODE.
//  Ports       : clk     - system clock, rising edge
//                rst_n   - asynchronous active-low reset
//                start   - conversion request, sampled only while idle
//                bin_in  - 14-bit unsigned operand, sampled with start
//                busy    - conversion in progress
//                done    - one-cycle pulse when new digits are valid
//                ovf     - last accepted operand exceeded 9999
//                dig0    - thousands digit (leftmost)
//                dig1    - hundreds digit
//                dig2    - tens digit
//                dig3    - units digit (rightmost)
//  Revision    : 1.0 - initial release
// ============================================================================
module bin2bcd_seq #(
    parameter bit         BLANK_LZ   = 1'b0,
    parameter logic [3:0] BLANK_CODE = 4'hF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [13:0] bin_in,
    output logic        busy,
    output logic        done,
    output logic        ovf,
    output logic [3:0]  dig0,
    output logic [3:0]  dig1,
    output logic [3:0]  dig2,
    output logic [3:0]  dig3
);

    // Value shown on the three upper digits after reset: a zero display
    // shows as a single "0" in the units position when blanking is enabled.
    localparam logic [3:0]  C_LZ_RST  = BLANK_LZ ? BLANK_CODE : 4'd0;
    localparam logic [13:0] C_MAX_BIN = 14'd9999;
    localparam logic [3:0]  C_LAST_IT = 4'd13;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_LOAD  = 2'd2
    } state_t;

    state_t      state_q;
    logic [29:0] scratch_q;    // {bcd[15:0], bin[13:0]}
    logic [3:0]  cnt_q;
    logic        pend_ovf_q;
    logic        busy_q;
    logic        done_q;
    logic        ovf_q;
    logic [3:0]  dig0_q;
    logic [3:0]  dig1_q;
    logic [3:0]  dig2_q;
    logic [3:0]  dig3_q;

    logic        sat_d;
    logic [13:0] operand_d;
    logic [29:0] adj_d;
    logic [29:0] scratch_d;
    logic [3:0]  dig0_d;
    logic [3:0]  dig1_d;
    logic [3:0]  dig2_d;
    logic [3:0]  dig3_d;

    // ------------------------------------------------------------------
    // Operand saturation
    // ------------------------------------------------------------------
    always_comb begin
        sat_d     = (bin_in > C_MAX_BIN);
        operand_d = sat_d ? C_MAX_BIN : bin_in;
    end

    // ------------------------------------------------------------------
    // One double-dabble step: every BCD nibble >= 5 gets +3, all judged on
    // the current value, then the whole scratch register shifts left by one.
    // ------------------------------------------------------------------
    always_comb begin
        adj_d = scratch_q;
        for (int i = 0; i < 4; i++) begin
            if (scratch_q[14 + 4*i +: 4] >= 4'd5) begin
                adj_d[14 + 4*i +: 4] = scratch_q[14 + 4*i +: 4] + 4'd3;
            end
        end
        scratch_d = adj_d << 1;
    end

    // ------------------------------------------------------------------
    // Final digits with optional leading-zero blanking. A digit is blanked
    // only while it and every more significant digit are zero; the units
    // digit always shows.
    // ------------------------------------------------------------------
    always_comb begin
        logic lead0;
        logic lead1;
        logic lead2;
        dig0_d = scratch_q[29:26];
        dig1_d = scratch_q[25:22];
        dig2_d = scratch_q[21:18];
        dig3_d = scratch_q[17:14];
        lead0  = BLANK_LZ && (scratch_q[29:26] == 4'd0);
        lead1  = lead0 && (scratch_q[25:22] == 4'd0);
        lead2  = lead1 && (scratch_q[21:18] == 4'd0);
        if (lead0) dig0_d = BLANK_CODE;
        if (lead1) dig1_d = BLANK_CODE;
        if (lead2) dig2_d = BLANK_CODE;
    end

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            scratch_q  <= '0;
            cnt_q      <= '0;
            pend_ovf_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            dig0_q     <= C_LZ_RST;
            dig1_q     <= C_LZ_RST;
            dig2_q     <= C_LZ_RST;
            dig3_q     <= 4'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // done lasts one cycle; a start in that same cycle is
                    // accepted, giving one conversion every 16 cycles.
                    done_q <= 1'b0;
                    if (start) begin
                        scratch_q  <= {16'd0, operand_d};
                        pend_ovf_q <= sat_d;
                        cnt_q      <= 4'd0;
                        busy_q     <= 1'b1;
                        state_q    <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    scratch_q <= scratch_d;
                    if (cnt_q == C_LAST_IT) begin
                        cnt_q   <= 4'd0;
                        state_q <= S_LOAD;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                S_LOAD: begin
                    dig0_q  <= dig0_d;
                    dig1_q  <= dig1_d;
                    dig2_q  <= dig2_d;
                    dig3_q  <= dig3_d;
                    ovf_q   <= pend_ovf_q;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign ovf  = ovf_q;
    assign dig0 = dig0_q;
    assign dig1 = dig1_q;
    assign dig2 = dig2_q;
    assign dig3 = dig3_q;

endmodule
`default_nettype wire

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
- Sequential binary-to-BCD converter feeding the 4-digit seven-segment scan stage.
- Accepts a 14-bit binary count on a start pulse and runs shift-and-add-3 (double-dabble), one bit per clock.
- Presents four registered BCD digits that stay stable between conversions, so the multiplexed display never shows partial results.
- Optional leading-zero blanking, plus saturation of out-of-range inputs to 9999.

Parameters:
- BLANK_LZ, 0: 1 = replace leading zero digits (thousands/hundreds/tens) with BLANK_CODE; the units digit is never blanked.
- BLANK_CODE, 4'hF: 4-bit code the downstream segment decoder renders as all-segments-off.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  conversion request; sampled only in IDLE.
- bin_in  input  14  unsigned binary value, 0..16383; sampled on the accepted start edge.
- busy  output  1  high while a conversion is in progress.
- done  output  1  single-cycle pulse when new digits are valid.
- ovf  output  1  high when the last accepted bin_in exceeded 9999; held until the next conversion completes.
- dig0  output  4  thousands digit (leftmost; first scan position).
- dig1  output  4  hundreds digit.
- dig2  output  4  tens digit.
- dig3  output  4  units digit (rightmost).

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; busy = 0, done = 0, ovf = 0.
  - dig3 = 0.
  - dig0..dig2 = 0 if BLANK_LZ = 0, else BLANK_CODE.
  - Internal shift and count registers cleared.
- States: IDLE, SHIFT, LOAD.
- IDLE:
  - If start = 1 at edge E0: latch operand; go to SHIFT; busy = 1.
  - Operand = bin_in if bin_in <= 9999, else 14'd9999 with pending_ovf = 1.
- SHIFT:
  - 30-bit scratch register = {bcd[15:0], bin[13:0]}, bcd initialised to 0.
  - Each cycle: every 4-bit BCD nibble >= 5 gets +3 (all nibbles evaluated in parallel from the current value), then the whole register shifts left 1.
  - 4-bit iteration counter runs 0..13.
  - After the 14th shift (edge E14) go to LOAD.
- LOAD (edge E15):
  - dig0..dig3 <= bcd nibbles [15:12]..[3:0], blanking applied.
  - ovf <= pending_ovf; done = 1 for exactly the cycle following E15; busy = 0; state = IDLE.
- Latency: start sampled at E0, digits and done visible after E15. Back-to-back throughput is one conversion per 16 cycles; a start held high during the done cycle is accepted.
- Blanking (BLANK_LZ = 1):
  - Scan from dig0 toward dig2; each digit is replaced by BLANK_CODE while it and all more-significant digits are 0.
  - Stop at the first nonzero digit; internal zeros are kept.
- start while busy (SHIFT or LOAD) is ignored: not queued, no effect on the conversion in flight.
- Outputs dig*/ovf change only at LOAD or reset; bin_in changes after E0 have no effect.
- Reset mid-conversion: immediate return to reset values; no done pulse; the previous digits are discarded.
- done and busy are never high in the same cycle.

Test Plan:
- Basic conversion: rst_n released, BLANK_LZ = 0, bin_in = 1234, start pulse at E0 -> busy high E0..E15; done high exactly 15 cycles after start sampled; dig0..dig3 = 1,2,3,4; ovf = 0.
- Extremes: bin_in = 0 -> 0,0,0,0; bin_in = 9999 -> 9,9,9,9 with ovf = 0.
- Saturation: bin_in = 12000 -> 9,9,9,9 with ovf = 1. Next conversion of 42 -> 0,0,4,2 with ovf = 0.
- Blanking, BLANK_LZ = 1:
  - 0 -> F,F,F,0
  - 7 -> F,F,F,7
  - 1005 -> 1,0,0,5
  - 80 -> F,F,8,0
- Ignored start: start 500, then re-assert start with bin_in = 321 at E5 -> result 0,5,0,0 and exactly one done pulse. start held continuously -> done every 16 cycles.
- Mid-operation reset: start 4321, pull rst_n low at E7 for 2 cycles -> busy = 0, dig* at reset values, no done pulse. Fresh start 4321 -> 4,3,2,1.
